led_controller: RTL and testbench

LED_CONTROLLER -- requirements
Module: led_controller

---
 rtl/led_controller.sv | 107 ++++++++++
 tb/tb_led_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/led_controller.sv
// Three-switch LED mode controller: synchronize and debounce active-low push
// switches, then step a four-state mode FSM that drives green/blue LEDs.
module led_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_HALF      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch4,
  output logic       led_green,
  output logic       led_blue,
  output logic [1:0] mode
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = $clog2(BLINK_HALF);

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_GREEN = 2'b01,
    ST_BLUE  = 2'b10,
    ST_BLINK = 2'b11
  } state_t;

  // Bit 0 = switch1, bit 1 = switch2, bit 2 = switch4 throughout.
  logic [2:0]    w_sw;
  logic [2:0]    r_meta;
  logic [2:0]    r_sync;
  logic [2:0]    r_db;
  logic [2:0]    r_db_d;
  logic [DW-1:0] r_db_cnt [3];
  logic [2:0]    w_evt;

  state_t        r_state;
  state_t        w_next;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic          r_led_g;
  logic          r_led_b;

  assign w_sw  = {switch4, switch2, switch1};
  assign w_evt = r_db_d & ~r_db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
      r_db   <= '1;
      r_db_d <= '1;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_meta <= w_sw;
      r_sync <= r_meta;
      r_db_d <= r_db;
      for (int i = 0; i < 3; i++) begin
        if (r_sync[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_db[i]     <= r_sync[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Fixed priority: a lower switch's simultaneous event is simply dropped.
  always_comb begin
    w_next = r_state;
    if (w_evt[0])      w_next = (r_state == ST_GREEN) ? ST_OFF : ST_GREEN;
    else if (w_evt[1]) w_next = (r_state == ST_BLUE)  ? ST_OFF : ST_BLUE;
    else if (w_evt[2]) w_next = (r_state == ST_BLINK) ? ST_OFF : ST_BLINK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_OFF;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_led_g     <= 1'b0;
      r_led_b     <= 1'b0;
    end else if (w_evt != 3'b000) begin
      r_state     <= w_next;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_led_g     <= (w_next == ST_GREEN) || (w_next == ST_BLINK);
      r_led_b     <= (w_next == ST_BLUE);
    end else if (r_state == ST_BLINK) begin
      if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
        r_led_g     <= r_phase;
        r_led_b     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  assign mode      = r_state;
  assign led_green = r_led_g;
  assign led_blue  = r_led_b;

endmodule

// File: tb/tb_led_controller.sv
// Randomized scoreboard bench for led_controller: expected mode changes are
// queued with their due edge; a monitor pops them and checks LEDs every cycle.
module tb_led_controller;

  localparam int D  = 4;
  localparam int BH = 3;

  logic       clk;
  logic       rst_n;
  logic       switch1;
  logic       switch2;
  logic       switch4;
  logic       led_green;
  logic       led_blue;
  logic [1:0] mode;

  led_controller #(.DEBOUNCE_CYCLES(D), .BLINK_HALF(BH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .switch1   (switch1),
    .switch2   (switch2),
    .switch4   (switch4),
    .led_green (led_green),
    .led_blue  (led_blue),
    .mode      (mode)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [33:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          entry = 0;
  logic [1:0]  last_mode = 2'b00;
  logic [1:0]  m_mode = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] model_next(input logic [1:0] cur, input logic [2:0] m);
    if (m[0]) return (cur == 2'd1) ? 2'd0 : 2'd1;
    if (m[1]) return (cur == 2'd2) ? 2'd0 : 2'd2;
    if (m[2]) return (cur == 2'd3) ? 2'd0 : 2'd3;
    return cur;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [33:0] e;
    logic [1:0]  exp_leds;
    int          k;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        last_mode = 2'b00;
        check("reset_outputs", {28'd0, mode, led_green, led_blue}, 32'd0);
      end else begin
        if (mode != last_mode) begin
          if (exp_q.size() == 0) begin
            check("unexpected_mode_change", {30'd0, mode}, {30'd0, last_mode});
          end else begin
            e = exp_q.pop_front();
            check("mode_value", {30'd0, mode}, {30'd0, e[33:32]});
            check("mode_latency_ok", ((cyc - int'(e[31:0])) inside {0, 1}) ? 32'd1 : 32'd0, 32'd1);
          end
          last_mode = mode;
          if (mode == 2'd3) entry = cyc;
        end
        case (last_mode)
          2'd0: exp_leds = 2'b00;
          2'd1: exp_leds = 2'b10;
          2'd2: exp_leds = 2'b01;
          default: begin
            k = cyc - entry;
            exp_leds = (((k / BH) % 2) == 0) ? 2'b10 : 2'b01;
          end
        endcase
        check("leds", {30'd0, led_green, led_blue}, {30'd0, exp_leds});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_sw(input logic [2:0] low_mask);
    switch1 = ~low_mask[0];
    switch2 = ~low_mask[1];
    switch4 = ~low_mask[2];
  endtask

  task automatic check_now();
    check("mode_settled", {30'd0, mode}, {30'd0, m_mode});
  endtask

  task automatic press(input logic [2:0] m, input int hold);
    int base;
    @(negedge clk);
    base = cyc;
    drive_sw(m);
    m_mode = model_next(m_mode, m);
    exp_q.push_back({m_mode, 32'(base + D + 3)});
    idle(hold);
    drive_sw(3'b000);
    idle($urandom_range(12, 20));
    check_now();
  endtask

  task automatic glitch(input logic [2:0] m, input int len);
    @(negedge clk);
    drive_sw(m);
    idle(len);
    drive_sw(3'b000);
    idle(12);
    check_now();
  endtask

  task automatic reset_mid_debounce(input logic [2:0] m);
    @(negedge clk);
    drive_sw(m);
    idle($urandom_range(1, 3));
    #2 rst_n = 1'b0;
    #1 check("async_reset_mode", {30'd0, mode}, 32'd0);
    check("async_reset_leds", {30'd0, led_green, led_blue}, 32'd0);
    @(negedge clk);
    drive_sw(3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    m_mode = 2'd0;
    idle(20);
    check_now();
  endtask

  task automatic reset_in_blink();
    int base;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!((last_mode == 2'd3) && (((cyc - entry) / BH) % 2 == 1)) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("blink_phase1_reached", (guard < 20) ? 32'd1 : 32'd0, 32'd1);
    #2 switch4 = 1'b0;
    rst_n = 1'b0;
    #1 check("blink_reset_mode", {30'd0, mode}, 32'd0);
    check("blink_reset_leds", {30'd0, led_green, led_blue}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    m_mode = 2'd3;
    exp_q.push_back({m_mode, 32'(base + D + 3)});
    idle(20);
    switch4 = 1'b1;
    idle(15);
    check_now();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    rst_n = 1'b0;
    drive_sw(3'b000);
    idle(3);
    check("reset_mode", {30'd0, mode}, 32'd0);
    check("reset_leds", {30'd0, led_green, led_blue}, 32'd0);
    rst_n = 1'b1;
    idle(5);
    check_now();

    press(3'b001, 20);
    glitch(3'b010, 3);
    press(3'b100, 8);
    idle(20);
    press(3'b100, 8);
    press(3'b011, 10);
    press(3'b001, 10);
    press(3'b100, 8);
    reset_in_blink();

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      press(3'($urandom_range(1, 7)), $urandom_range(5, 20));
      else if (r <= 7) glitch(3'($urandom_range(1, 7)), $urandom_range(1, 3));
      else if (r == 8) reset_mid_debounce(3'($urandom_range(1, 7)));
      else             idle($urandom_range(1, 30));
    end

    idle(30);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
